qr_text_buffer: RTL and testbench

QR_TEXT_BUFFER -- requirements
Module: qr_text_buffer

---
 rtl/qr_text_buffer_if.sv | 30 +++
 rtl/qr_text_buffer.sv | 170 +++++++++++++++++
 tb/tb_qr_text_buffer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qr_text_buffer_if.sv
// qr_text_buffer_if: upstream byte strobe, downstream stream and status
// signals of the QR text buffer, bundled for one port connection.
interface qr_text_buffer_if #(
   parameter int DEPTH = 32
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          decode_valid;
   logic [7:0]    decode_jis8_code;
   logic          qr_decode_finish;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_last;
   logic [LW-1:0] msg_len;
   logic          overflow;
   logic          busy;

   // Environment side: drives the decoder strobes and the downstream accept.
   modport master (
      output decode_valid, decode_jis8_code, qr_decode_finish, out_ready,
      input  out_valid, out_data, out_last, msg_len, overflow, busy
   );

   // Buffer side.
   modport slave (
      input  decode_valid, decode_jis8_code, qr_decode_finish, out_ready,
      output out_valid, out_data, out_last, msg_len, overflow, busy
   );
endinterface

// File: rtl/qr_text_buffer.sv
// qr_text_buffer: collects decoded JIS8 bytes of one QR message into a
// DEPTH-byte store, then streams them out with a valid/ready handshake.
// Optional feature macro QR_TEXT_CHECKSUM_EN appends an XOR checksum beat
// after the last data byte (excluded from msg_len).
module qr_text_buffer #(
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             srstn,
   qr_text_buffer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [7:0]  mem [DEPTH];
   logic [AW:0] count_q, count_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] msg_len_q, msg_len_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        we;
   logic [AW-1:0] waddr;
   logic [AW:0] fill_len;   // stored length after this cycle's write
   logic [AW:0] nxt_ptr;    // beat index following the presented one
`ifdef QR_TEXT_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
   localparam logic SINGLE_IS_LAST = 1'b0;  // checksum beat always follows
`else
   localparam logic SINGLE_IS_LAST = 1'b1;
`endif

   // Next-state, store write and output-register update.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      msg_len_d   = msg_len_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      overflow_d  = overflow_q;
      we          = 1'b0;
      waddr       = count_q[AW-1:0];
      fill_len    = count_q;
      nxt_ptr     = rd_ptr_q + 1'b1;
`ifdef QR_TEXT_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.decode_valid) begin
               // message start: first byte lands at address 0
               we         = 1'b1;
               waddr      = '0;
               count_d    = ONE;
               overflow_d = 1'b0;
               msg_len_d  = '0;
`ifdef QR_TEXT_CHECKSUM_EN
               csum_d     = bus.decode_jis8_code;
`endif
               if (bus.qr_decode_finish) begin
                  // one-byte message; store is bypassed for the first beat
                  msg_len_d   = ONE;
                  state_d     = DRAIN;
                  out_valid_d = 1'b1;
                  out_data_d  = bus.decode_jis8_code;
                  rd_ptr_d    = '0;
                  out_last_d  = SINGLE_IS_LAST;
               end else begin
                  state_d = COLLECT;
               end
            end else if (bus.qr_decode_finish) begin
               msg_len_d = '0;
            end
         end
         COLLECT: begin
            if (bus.decode_valid) begin
               if (count_q != FULL) begin
                  we       = 1'b1;
                  fill_len = count_q + 1'b1;
`ifdef QR_TEXT_CHECKSUM_EN
                  csum_d   = csum_q ^ bus.decode_jis8_code;
`endif
               end else begin
                  overflow_d = 1'b1;
               end
            end
            count_d = fill_len;
            if (bus.qr_decode_finish) begin
               // address 0 was written on an earlier cycle, safe to read now
               msg_len_d   = fill_len;
               state_d     = DRAIN;
               out_valid_d = 1'b1;
               out_data_d  = mem[0];
               rd_ptr_d    = '0;
               out_last_d  = SINGLE_IS_LAST & (fill_len == ONE);
            end
         end
         DRAIN: begin
            if (bus.decode_valid) overflow_d = 1'b1;
            if (out_valid_q && bus.out_ready) begin
               if (out_last_q) begin
                  state_d     = IDLE;
                  count_d     = '0;
                  rd_ptr_d    = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  rd_ptr_d = nxt_ptr;
`ifdef QR_TEXT_CHECKSUM_EN
                  out_data_d = (nxt_ptr == msg_len_q) ? csum_q : mem[nxt_ptr[AW-1:0]];
                  out_last_d = (nxt_ptr == msg_len_q);
`else
                  out_data_d = mem[nxt_ptr[AW-1:0]];
                  out_last_d = (nxt_ptr == msg_len_q - 1'b1);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         msg_len_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef QR_TEXT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         msg_len_q   <= msg_len_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
`ifdef QR_TEXT_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Message store; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= bus.decode_jis8_code;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.msg_len   = msg_len_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_qr_text_buffer.sv
// tb_qr_text_buffer: directed scenarios plus randomized messages, checked
// every cycle against a message-level model (byte list + beat list).
module tb_qr_text_buffer;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic srstn = 1'b0;
   always #5 clk = ~clk;

   qr_text_buffer_if #(.DEPTH(DEPTH)) bus ();
   qr_text_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .srstn(srstn), .bus(bus));

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;

   // model: 0 idle, 1 collecting, 2 streaming
   int          m_mode;
   byte unsigned m_store[$];
   byte unsigned m_beats[$];
   int          m_idx;
   int          m_len;
   bit          m_ovf;

   byte unsigned seen[$];
   int           stamps[$];
   byte unsigned q[$];
   byte unsigned e[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0;
      m_store.delete();
      m_beats.delete();
      m_idx = 0;
      m_len = 0;
      m_ovf = 1'b0;
   endfunction

   function automatic void start_drain();
      byte unsigned x = 8'h00;
      m_beats = m_store;
`ifdef QR_TEXT_CHECKSUM_EN
      foreach (m_store[i]) x = x ^ m_store[i];
      m_beats.push_back(x);
`endif
      m_len  = m_store.size();
      m_idx  = 0;
      m_mode = 2;
   endfunction

   function automatic void model_step();
      byte unsigned d = bus.decode_jis8_code;
      case (m_mode)
         0: begin
            if (bus.decode_valid) begin
               m_store.delete();
               m_store.push_back(d);
               m_ovf = 1'b0;
               m_len = 0;
               if (bus.qr_decode_finish) start_drain();
               else m_mode = 1;
            end else if (bus.qr_decode_finish) begin
               m_len = 0;
            end
         end
         1: begin
            if (bus.decode_valid) begin
               if (m_store.size() < DEPTH) m_store.push_back(d);
               else m_ovf = 1'b1;
            end
            if (bus.qr_decode_finish) start_drain();
         end
         default: begin
            if (bus.decode_valid) m_ovf = 1'b1;
            if (bus.out_ready) begin
               m_idx++;
               if (m_idx == m_beats.size()) m_mode = 0;
            end
         end
      endcase
   endfunction

   // model advance on each active edge
   always @(posedge clk) begin
      cyc_n = cyc_n + 1;
      if (srstn) model_step();
   end

   // per-cycle compare, away from the active edge
   always @(negedge clk) begin
      chk("out_valid", bus.out_valid, 32'(m_mode == 2));
      chk("busy", bus.busy, 32'(m_mode != 0));
      chk("msg_len", bus.msg_len, m_len);
      chk("overflow", bus.overflow, m_ovf);
      if (m_mode == 2 && bus.out_valid === 1'b1) begin
         chk("out_data", bus.out_data, m_beats[m_idx]);
         chk("out_last", bus.out_last, 32'(m_idx == m_beats.size() - 1));
         if (bus.out_ready === 1'b1) begin
            seen.push_back(bus.out_data);
            stamps.push_back(cyc_n);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input byte unsigned b[$], input bit gaps, input bit fin_last);
      foreach (b[i]) begin
         if (gaps) while ($urandom_range(0, 3) == 0) step();
         bus.decode_valid     = 1'b1;
         bus.decode_jis8_code = b[i];
         bus.qr_decode_finish = fin_last && (i == b.size() - 1);
         step();
         bus.decode_valid     = 1'b0;
         bus.qr_decode_finish = 1'b0;
      end
      if (!fin_last) begin
         if (gaps) while ($urandom_range(0, 3) == 0) step();
         bus.qr_decode_finish = 1'b1;
         step();
         bus.qr_decode_finish = 1'b0;
      end
   endtask

   // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready + noise
   task automatic drain(input int mode);
      int n = 0;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (bus.busy === 1'b1 && n < 400) begin
         case (mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = pat[n % 4];
            default: begin
               bus.out_ready        = ($urandom_range(0, 3) != 0);
               bus.decode_valid     = ($urandom_range(0, 7) == 0);
               bus.decode_jis8_code = 8'($urandom);
               bus.qr_decode_finish = ($urandom_range(0, 7) == 0);
            end
         endcase
         step();
         n++;
      end
      bus.out_ready        = 1'b0;
      bus.decode_valid     = 1'b0;
      bus.qr_decode_finish = 1'b0;
      chk("drain_timeout", bus.busy, 0);
   endtask

   task automatic chk_seen(input string nm);
      chk({nm, "_beats"}, seen.size(), e.size());
      foreach (e[i]) if (i < seen.size()) chk({nm, "_byte"}, seen[i], e[i]);
   endtask

   task automatic clr();
      seen.delete();
      stamps.delete();
      q.delete();
      e.delete();
   endtask

   initial begin
      bus.decode_valid     = 1'b0;
      bus.decode_jis8_code = 8'h00;
      bus.qr_decode_finish = 1'b0;
      bus.out_ready        = 1'b0;
      model_reset();
      repeat (3) step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_msg_len", bus.msg_len, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_busy", bus.busy, 0);
      srstn = 1'b1;
      step();

      // "HI!" streamed back-to-back
      clr();
      q.push_back(8'h48); q.push_back(8'h49); q.push_back(8'h21);
      send(q, 1'b0, 1'b0);
      drain(0);
      e.push_back(8'h48); e.push_back(8'h49); e.push_back(8'h21);
`ifdef QR_TEXT_CHECKSUM_EN
      e.push_back(8'h20);
`endif
      chk_seen("hi");
      chk("hi_msg_len", bus.msg_len, 3);
      chk("hi_overflow", bus.overflow, 0);
      if (stamps.size() > 0) chk("hi_back_to_back", stamps[stamps.size()-1] - stamps[0], e.size() - 1);

      // overflow: 34 bytes into a 32-byte store
      clr();
      for (int i = 0; i < 34; i++) q.push_back(8'(i));
      send(q, 1'b0, 1'b0);
      drain(0);
      for (int i = 0; i < 32; i++) e.push_back(8'(i));
`ifdef QR_TEXT_CHECKSUM_EN
      e.push_back(8'h00);
`endif
      chk_seen("ovf");
      chk("ovf_msg_len", bus.msg_len, 32);
      chk("ovf_flag", bus.overflow, 1);

      // single byte with finish in the same cycle
      clr();
      q.push_back(8'h41);
      send(q, 1'b0, 1'b1);
      drain(0);
      e.push_back(8'h41);
`ifdef QR_TEXT_CHECKSUM_EN
      e.push_back(8'h41);
`endif
      chk_seen("one");
      chk("one_msg_len", bus.msg_len, 1);

      // stalls: ready 1,0,0,1
      clr();
      q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3); q.push_back(8'hD4);
      send(q, 1'b0, 1'b0);
      drain(1);
      e = q;
`ifdef QR_TEXT_CHECKSUM_EN
      e.push_back(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
`endif
      chk_seen("stall");

      // reset mid-stream after 2 of 5 bytes
      clr();
      q.push_back(8'h10); q.push_back(8'h20); q.push_back(8'h30); q.push_back(8'h40); q.push_back(8'h50);
      send(q, 1'b0, 1'b0);
      begin
         int n = 0;
         bus.out_ready = 1'b1;
         while (seen.size() < 2 && n < 20) begin step(); n++; end
         chk("mid_rst_reach", seen.size(), 2);
      end
      bus.out_ready = 1'b0;
      srstn = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_msg_len", bus.msg_len, 0);
      chk("mid_rst_busy", bus.busy, 0);
      step();
      step();
      srstn = 1'b1;
      step();
      clr();
      q.push_back(8'h5A); q.push_back(8'h6B); q.push_back(8'h7C);
      send(q, 1'b0, 1'b0);
      drain(0);
      e = q;
`ifdef QR_TEXT_CHECKSUM_EN
      e.push_back(8'h5A ^ 8'h6B ^ 8'h7C);
`endif
      chk_seen("after_rst");

      // finish alone in IDLE
      bus.qr_decode_finish = 1'b1;
      step();
      bus.qr_decode_finish = 1'b0;
      repeat (3) step();
      chk("fin_idle_valid", bus.out_valid, 0);
      chk("fin_idle_busy", bus.busy, 0);
      chk("fin_idle_msg_len", bus.msg_len, 0);

      // randomized messages
      for (int m = 0; m < 25; m++) begin
         int len;
         clr();
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            bus.qr_decode_finish = 1'b1;
            step();
            bus.qr_decode_finish = 1'b0;
         end
         send(q, 1'b1, 1'($urandom_range(0, 1)));
         drain(2);
         chk("rnd_msg_len", bus.msg_len, (len < DEPTH) ? len : DEPTH);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
